// File: rtl/l1_prefetch_pkg.sv
// Shared constants, FSM states and width helpers for the L1 stride prefetcher.
package l1_prefetch_pkg;

    localparam logic [4:0] M_XRD = 5'd0;
    localparam logic [4:0] M_XWR = 5'd1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } pf_state_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] last;
        logic [31:0] stride;
        logic [1:0]  conf;
    } stream_max_t;

    function automatic int line_w(input int addr_bits, input int line_shift);
        return addr_bits - line_shift;
    endfunction

endpackage

// File: rtl/l1_stride_prefetcher_queue.sv
// Synchronous FIFO of prefetch requests; full is judged before any same-cycle pop.
module prefetch_queue
    import l1_prefetch_pkg::*;
#(
    parameter int W     = 41,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [PW:0]  r_wp;
    logic [PW:0]  r_rp;
    logic         w_empty;

    assign w_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[PW] != r_rp[PW]) &&
                     (r_wp[PW-1:0] == r_rp[PW-1:0]);
    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rp[PW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push && !o_full) r_wp <= r_wp + 1'b1;
            if (o_valid && i_ready) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (i_push && !o_full) r_mem[r_wp[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/l1_stride_prefetcher.sv
// Multi-stream stride prefetcher trained on delayed L1 miss flags.
module l1_stride_prefetcher
    import l1_prefetch_pkg::*;
#(
    parameter int ADDR_BITS   = 40,
    parameter int TAG_BITS    = 8,
    parameter int CMD_BITS    = 5,
    parameter int SIZE_BITS   = 2,
    parameter int LINE_SHIFT  = 6,
    parameter int STREAMS     = 4,
    parameter int STRIDE_BITS = 12,
    parameter int DEGREE      = 2,
    parameter int CONF_THRESH = 1,
    parameter int QDEPTH      = 4,
    parameter int PAGE_SHIFT  = 12,
    parameter int WRITE_HINT  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_req_valid,
    input  logic [ADDR_BITS-1:0] cpu_req_bits_addr,
    input  logic [TAG_BITS-1:0]  cpu_req_bits_tag,
    input  logic [CMD_BITS-1:0]  cpu_req_bits_cmd,
    input  logic [SIZE_BITS-1:0] cpu_req_bits_size,
    input  logic                 cpu_req_bits_signed,
    input  logic                 cpu_miss,
    input  logic                 cfg_enable,
    input  logic                 dmem_ready,
    output logic                 dmem_valid,
    output logic [ADDR_BITS-1:0] dmem_bits_addr,
    output logic                 dmem_bits_write
);

    localparam int LW = line_w(ADDR_BITS, LINE_SHIFT);
    localparam int SB = STRIDE_BITS;
    localparam int PG = PAGE_SHIFT - LINE_SHIFT;
    localparam int VW = (STREAMS > 1) ? $clog2(STREAMS) : 1;
    localparam int KW = 4;

    typedef struct packed {
        logic          valid;
        logic [LW-1:0] last;
        logic [SB-1:0] stride;
        logic [1:0]    conf;
    } stream_t;

    logic w_unused;
    assign w_unused = ^{cpu_req_bits_tag, cpu_req_bits_size,
                        cpu_req_bits_signed,
                        cpu_req_bits_addr[LINE_SHIFT-1:0]};

    logic          r_s1_v, r_s2_v, r_s1_st, r_s2_st;
    logic [LW-1:0] r_s1_l, r_s2_l;
    logic          w_req_ok;

    assign w_req_ok = cpu_req_valid &&
        (cpu_req_bits_cmd == CMD_BITS'(M_XRD) ||
         cpu_req_bits_cmd == CMD_BITS'(M_XWR));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s1_v  <= 1'b0;
            r_s2_v  <= 1'b0;
            r_s1_st <= 1'b0;
            r_s2_st <= 1'b0;
            r_s1_l  <= '0;
            r_s2_l  <= '0;
        end else begin
            r_s1_v  <= w_req_ok;
            r_s1_l  <= cpu_req_bits_addr[ADDR_BITS-1:LINE_SHIFT];
            r_s1_st <= (cpu_req_bits_cmd == CMD_BITS'(M_XWR));
            r_s2_v  <= r_s1_v;
            r_s2_l  <= r_s1_l;
            r_s2_st <= r_s1_st;
        end
    end

    stream_t        r_tab [STREAMS];
    logic [VW-1:0]  r_victim;
    logic [LW:0]    w_d [STREAMS];
    logic           w_hit, w_inv, w_train, w_dzero, w_fire;
    logic [VW-1:0]  w_hit_idx, w_inv_idx, w_alloc_idx;
    logic [SB-1:0]  w_hd;
    logic [1:0]     w_conf;
    logic [LW-SB+1:0] w_top;

    always_comb begin
        w_hit     = 1'b0;
        w_inv     = 1'b0;
        w_hit_idx = '0;
        w_inv_idx = '0;
        w_top     = '0;
        for (int i = STREAMS - 1; i >= 0; i--) begin
            w_d[i] = {1'b0, r_s2_l} - {1'b0, r_tab[i].last};
            w_top  = w_d[i][LW:SB-1];
            if (r_tab[i].valid && (&w_top || ~|w_top)) begin
                w_hit     = 1'b1;
                w_hit_idx = VW'(i);
            end
            if (!r_tab[i].valid) begin
                w_inv     = 1'b1;
                w_inv_idx = VW'(i);
            end
        end
    end

    pf_state_e r_state, w_state_nxt;

    assign w_train     = r_s2_v && cpu_miss && cfg_enable;
    assign w_hd        = w_d[w_hit_idx][SB-1:0];
    assign w_dzero     = (w_d[w_hit_idx] == '0);
    assign w_alloc_idx = w_inv ? w_inv_idx : r_victim;
    assign w_conf      = (w_hd != r_tab[w_hit_idx].stride) ? 2'd0 :
                         (r_tab[w_hit_idx].conf == 2'd3) ? 2'd3 :
                         r_tab[w_hit_idx].conf + 2'd1;
    assign w_fire      = w_train && w_hit && !w_dzero &&
                         (w_conf >= 2'(CONF_THRESH)) && (r_state == ST_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < STREAMS; i++) r_tab[i] <= '0;
            r_victim <= '0;
        end else if (w_train) begin
            if (w_hit) begin
                if (!w_dzero) begin
                    r_tab[w_hit_idx].stride <= w_hd;
                    r_tab[w_hit_idx].conf   <= w_conf;
                    r_tab[w_hit_idx].last   <= r_s2_l;
                end
            end else begin
                r_tab[w_alloc_idx] <= '{valid: 1'b1, last: r_s2_l,
                                        stride: '0, conf: 2'd0};
                if (!w_inv)
                    r_victim <= (r_victim == VW'(STREAMS - 1)) ?
                                '0 : r_victim + 1'b1;
            end
        end
    end

    logic [LW-1:0]   r_base, r_last_push;
    logic [SB-1:0]   r_bstride;
    logic            r_bstore;
    logic [KW-1:0]   r_k;
    logic [LW+1:0]   w_step, w_sum;
    logic [LW-1:0]   w_p;
    logic            w_abort, w_dup, w_lastk, w_push, w_kinc, w_full;

    // Two guard bits expose any carry or borrow out of the line-number width.
    assign w_step  = (LW + 2)'(r_k) *
                     {{(LW + 2 - SB){r_bstride[SB-1]}}, r_bstride};
    assign w_sum   = {2'b00, r_base} + w_step;
    assign w_p     = w_sum[LW-1:0];
    assign w_abort = (|w_sum[LW+1:LW]) || (w_p[LW-1:PG] != r_base[LW-1:PG]);
    assign w_dup   = (w_p == r_last_push);
    assign w_lastk = (r_k == KW'(DEGREE));

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_kinc      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fire) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_dup) begin
                    w_kinc = 1'b1;
                    if (w_lastk) w_state_nxt = ST_IDLE;
                end else if (!w_full) begin
                    w_push = 1'b1;
                    w_kinc = 1'b1;
                    if (w_lastk) w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_base      <= '0;
            r_bstride   <= '0;
            r_bstore    <= 1'b0;
            r_k         <= '0;
            r_last_push <= '0;
        end else begin
            if (w_fire) begin
                r_base    <= r_s2_l;
                r_bstride <= w_hd;
                r_bstore  <= r_s2_st;
                r_k       <= KW'(1);
            end else if (w_kinc) begin
                r_k <= r_k + 1'b1;
            end
            if (w_push) r_last_push <= w_p;
        end
    end

    logic [ADDR_BITS:0] w_qin, w_qout;

    assign w_qin = {w_p, {LINE_SHIFT{1'b0}},
                    (WRITE_HINT != 0) && r_bstore};
    assign dmem_bits_addr  = w_qout[ADDR_BITS:1];
    assign dmem_bits_write = w_qout[0];

    prefetch_queue #(
        .W     (ADDR_BITS + 1),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_qin),
        .o_full  (w_full),
        .o_valid (dmem_valid),
        .i_ready (dmem_ready),
        .o_data  (w_qout)
    );

endmodule

// File: tb/tb_l1_stride_prefetcher.sv
// Directed bench: default prefetcher plus a DEGREE=6, WRITE_HINT=0 copy.
module tb_l1_stride_prefetcher;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic [39:0] cpu_req_bits_addr = '0;
    logic [7:0]  cpu_req_bits_tag = '0;
    logic [4:0]  cpu_req_bits_cmd = '0;
    logic [1:0]  cpu_req_bits_size = '0;
    logic        cpu_req_bits_signed = 1'b0;
    logic        cpu_miss = 1'b0;
    logic        cfg_enable = 1'b1;
    logic        ready1 = 1'b1;
    logic        ready2 = 1'b1;
    logic        valid1, valid2, write1, write2;
    logic [39:0] addr1, addr2;

    int checks = 0;
    int errors = 0;
    logic [40:0] got1[$];
    logic [40:0] got2[$];

    always #5 clock = ~clock;

    l1_stride_prefetcher u_dut1 (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_bits_addr(cpu_req_bits_addr),
        .cpu_req_bits_tag(cpu_req_bits_tag),
        .cpu_req_bits_cmd(cpu_req_bits_cmd),
        .cpu_req_bits_size(cpu_req_bits_size),
        .cpu_req_bits_signed(cpu_req_bits_signed),
        .cpu_miss(cpu_miss), .cfg_enable(cfg_enable),
        .dmem_ready(ready1), .dmem_valid(valid1),
        .dmem_bits_addr(addr1), .dmem_bits_write(write1)
    );

    l1_stride_prefetcher #(.DEGREE(6), .WRITE_HINT(0)) u_dut2 (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_bits_addr(cpu_req_bits_addr),
        .cpu_req_bits_tag(cpu_req_bits_tag),
        .cpu_req_bits_cmd(cpu_req_bits_cmd),
        .cpu_req_bits_size(cpu_req_bits_size),
        .cpu_req_bits_signed(cpu_req_bits_signed),
        .cpu_miss(cpu_miss), .cfg_enable(cfg_enable),
        .dmem_ready(ready2), .dmem_valid(valid2),
        .dmem_bits_addr(addr2), .dmem_bits_write(write2)
    );

    always @(negedge clock) begin
        if (reset && valid1 && ready1) got1.push_back({addr1, write1});
        if (reset && valid2 && ready2) got2.push_back({addr2, write2});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
        tick();
        got1.delete();
        got2.delete();
    endtask

    task automatic req(input logic [39:0] a, input logic [4:0] c,
                       input int dly);
        cpu_req_valid = 1'b1;
        cpu_req_bits_addr = a;
        cpu_req_bits_cmd = c;
        tick();
        cpu_req_valid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            cpu_miss = (i == dly);
            tick();
        end
        cpu_miss = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_req_valid = 1'b1;
            cpu_miss = 1'b1;
            cpu_req_bits_cmd = 5'd0;
            cpu_req_bits_addr = 40'h1000 + 40'(i * 64);
            tick();
            checks++;
            if (valid1 !== 1'b0 || addr1 !== 40'h0 || write1 !== 1'b0 ||
                valid2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d valid=%b addr=%h wr=%b exp 0",
                         i, valid1, addr1, write1);
            end
        end
        cpu_req_valid = 1'b0;
        cpu_miss = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (valid1 !== 1'b0 || valid2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d valid=%b/%b exp 0",
                         i, valid1, valid2);
            end
        end
    endtask

    task automatic test_stride_up();
        logic [40:0] exp1 [2];
        logic [40:0] g;
        exp1[0] = {40'h10C0, 1'b0};
        exp1[1] = {40'h1100, 1'b0};
        do_reset();
        req(40'h1000, 5'd0, 2);
        req(40'h1040, 5'd0, 2);
        req(40'h1080, 5'd0, 2);
        checks++;
        if (valid1 !== 1'b0) begin
            errors++;
            $display("FAIL lat_t1 valid=%b exp 0", valid1);
        end
        tick();
        checks++;
        if (valid1 !== 1'b1 || addr1 !== 40'h10C0) begin
            errors++;
            $display("FAIL lat_t2 valid=%b addr=%h exp 1 10c0", valid1, addr1);
        end
        ticks(6);
        checks++;
        if (got1.size() != 2) begin
            errors++;
            $display("FAIL up_count got %0d exp 2", got1.size());
        end
        for (int i = 0; i < 2; i++) begin
            g = (i < got1.size()) ? got1[i] : 'x;
            checks++;
            if (g !== exp1[i]) begin
                errors++;
                $display("FAIL up_addr%0d got %h exp %h", i, g, exp1[i]);
            end
        end
        got1.delete();
        req(40'h10C0, 5'd0, 2);
        ticks(6);
        g = (got1.size() > 0) ? got1[0] : 'x;
        checks++;
        if (got1.size() != 1 || g !== {40'h1140, 1'b0}) begin
            errors++;
            $display("FAIL dup_suppress got n=%0d first=%h exp n=1 %h",
                     got1.size(), g, {40'h1140, 1'b0});
        end
    endtask

    task automatic test_store_down();
        logic [40:0] g;
        logic [39:0] e;
        do_reset();
        req(40'h8000, 5'd1, 2);
        req(40'h7F00, 5'd1, 2);
        req(40'h7E00, 5'd1, 2);
        ticks(12);
        checks++;
        if (got1.size() != 2) begin
            errors++;
            $display("FAIL st_count got %0d exp 2", got1.size());
        end
        for (int i = 0; i < 2; i++) begin
            e = 40'h7D00 - 40'(i * 256);
            g = (i < got1.size()) ? got1[i] : 'x;
            checks++;
            if (g !== {e, 1'b1}) begin
                errors++;
                $display("FAIL st_addr%0d got %h exp %h", i, g, {e, 1'b1});
            end
        end
        checks++;
        if (got2.size() != 6) begin
            errors++;
            $display("FAIL st_nohint_count got %0d exp 6", got2.size());
        end
        for (int i = 0; i < 6; i++) begin
            e = 40'h7D00 - 40'(i * 256);
            g = (i < got2.size()) ? got2[i] : 'x;
            checks++;
            if (g !== {e, 1'b0}) begin
                errors++;
                $display("FAIL st_nohint%0d got %h exp %h", i, g, {e, 1'b0});
            end
        end
    endtask

    task automatic test_page_clip();
        logic [40:0] g;
        do_reset();
        req(40'h1F00, 5'd0, 2);
        req(40'h1F40, 5'd0, 2);
        req(40'h1F80, 5'd0, 2);
        ticks(12);
        g = (got1.size() > 0) ? got1[0] : 'x;
        checks++;
        if (got1.size() != 1 || g !== {40'h1FC0, 1'b0}) begin
            errors++;
            $display("FAIL page_clip got n=%0d first=%h exp n=1 %h",
                     got1.size(), g, {40'h1FC0, 1'b0});
        end
        checks++;
        if (got2.size() != 1) begin
            errors++;
            $display("FAIL page_clip_d6 got %0d exp 1", got2.size());
        end
    endtask

    task automatic test_miss_align();
        logic [40:0] g;
        do_reset();
        req(40'h5000, 5'd0, 1);
        req(40'h5040, 5'd0, 1);
        req(40'h5080, 5'd0, 1);
        ticks(6);
        checks++;
        if (got1.size() != 0) begin
            errors++;
            $display("FAIL early_miss got %0d exp 0", got1.size());
        end
        req(40'h5000, 5'd2, 2);
        req(40'h5040, 5'd2, 2);
        req(40'h5080, 5'd2, 2);
        ticks(6);
        checks++;
        if (got1.size() != 0) begin
            errors++;
            $display("FAIL cmd2_train got %0d exp 0", got1.size());
        end
        req(40'h5000, 5'd0, 2);
        req(40'h5040, 5'd0, 2);
        req(40'h5080, 5'd0, 2);
        ticks(6);
        g = (got1.size() > 1) ? got1[1] : 'x;
        checks++;
        if (got1.size() != 2 || g !== {40'h5100, 1'b0}) begin
            errors++;
            $display("FAIL aligned_train got n=%0d second=%h exp n=2 %h",
                     got1.size(), g, {40'h5100, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] e;
        do_reset();
        ready2 = 1'b0;
        req(40'h3000, 5'd0, 2);
        req(40'h3040, 5'd0, 2);
        req(40'h3080, 5'd0, 2);
        ticks(8);
        checks++;
        if (valid2 !== 1'b1 || addr2 !== 40'h30C0 || write2 !== 1'b0) begin
            errors++;
            $display("FAIL stall_head valid=%b addr=%h exp 1 30c0",
                     valid2, addr2);
        end
        ticks(3);
        checks++;
        if (valid2 !== 1'b1 || addr2 !== 40'h30C0 || got2.size() != 0) begin
            errors++;
            $display("FAIL stall_stable valid=%b addr=%h n=%0d exp 1 30c0 0",
                     valid2, addr2, got2.size());
        end
        ready2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = 40'h30C0 + 40'(i * 64);
            checks++;
            if (valid2 !== 1'b1 || addr2 !== e) begin
                errors++;
                $display("FAIL drain%0d valid=%b addr=%h exp 1 %h",
                         i, valid2, addr2, e);
            end
            tick();
        end
        checks++;
        if (valid2 !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty valid=%b exp 0", valid2);
        end
        do_reset();
        ready2 = 1'b0;
        req(40'h3000, 5'd0, 2);
        req(40'h3040, 5'd0, 2);
        req(40'h3080, 5'd0, 2);
        ticks(2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        ready2 = 1'b1;
        checks++;
        if (valid2 !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset valid=%b exp 0", valid2);
        end
        ticks(10);
        checks++;
        if (valid2 !== 1'b0 || got2.size() != 0) begin
            errors++;
            $display("FAIL midburst_discard valid=%b n=%0d exp 0 0",
                     valid2, got2.size());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_stride_up();
        test_store_down();
        test_page_clip();
        test_miss_align();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_stride_prefetcher.md
Name: l1_stride_prefetcher

Overview:
- Synthesizable, parametrised successor to the DPI-modelled L1 data prefetcher. It sits beside the L1 D-cache, snoops CPU requests and the delayed miss flag, and trains a multi-stream stride table.
- Confident streams issue DEGREE line prefetches through a buffered valid/ready port to the dmem side.
- Adds multi-stream tracking, configurable degree, page-boundary clipping, duplicate suppression and backpressure buffering.

Parameters:
- ADDR_BITS, 40, physical address width
- TAG_BITS, 8, cpu_req tag width (snooped only)
- CMD_BITS, 5, memory command width
- SIZE_BITS, 2, access size width
- LINE_SHIFT, 6, log2 cache-line bytes
- STREAMS, 4, stride-table entries (>=1)
- STRIDE_BITS, 12, signed stride width in lines
- DEGREE, 2, prefetches per trigger (1..8)
- CONF_THRESH, 1, confidence (0..3) needed to issue
- QDEPTH, 4, output queue depth (power of 2, >=2)
- PAGE_SHIFT, 12, prefetches never cross a 2^PAGE_SHIFT region
- WRITE_HINT, 1, 1 = forward store intent on dmem_bits_write

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low: logic resets on a clock edge while reset==0
- cpu_req_valid  in  1  CPU request valid
- cpu_req_bits_addr  in  ADDR_BITS  request byte address
- cpu_req_bits_tag  in  TAG_BITS  unused beyond snooping
- cpu_req_bits_cmd  in  CMD_BITS  0=M_XRD, 1=M_XWR; others never train
- cpu_req_bits_size  in  SIZE_BITS  unused
- cpu_req_bits_signed  in  1  unused
- cpu_miss  in  1  miss flag, 2 cycles after its cpu_req
- cfg_enable  in  1  0 = no training, queue still drains
- dmem_ready  in  1  downstream accepts prefetch
- dmem_valid  out  1  prefetch valid
- dmem_bits_addr  out  ADDR_BITS  line-aligned prefetch address
- dmem_bits_write  out  1  prefetch-exclusive hint

Behaviour:
- Reset (reset==0 at edge): dmem_valid=0, dmem_bits_addr=0, dmem_bits_write=0; table invalid; queue empty; FSM IDLE; delay line cleared. Reset mid-burst discards the burst and the queue.
- Delay line: 2-stage shift of {valid & cmd in {XRD,XWR}, line L=addr>>LINE_SHIFT, is_store}. A training event occurs in cycle T when stage-2 valid & cpu_miss & cfg_enable.
- Lookup: hit = valid entry with d=L-last (signed, line units) in [-2^(STRIDE_BITS-1), 2^(STRIDE_BITS-1)-1]. Multiple hits: lowest index wins. d==0: no update, no issue.
- Hit update: if d==stride then conf=min(conf+1,3), else stride=d and conf=0. last=L. If the new conf>=CONF_THRESH and FSM is IDLE, latch base=L, stride, and is_store, then go to ISSUE.
- No hit: allocate the lowest invalid entry, else the round-robin victim pointer (pointer then advances mod STREAMS). Set last=L, stride=0, conf=0.
- FSM IDLE/ISSUE; k counts 1..DEGREE. Each ISSUE cycle computes P=base+k*stride (line width ADDR_BITS-LINE_SHIFT).
  - P in a different page region than base, or carry/borrow out of the line width: abort to IDLE, no push.
  - P equals the last pushed line: skip, k++, no push.
  - Queue full: hold k and stall.
  - Otherwise push, k++.
  - Exit to IDLE after k==DEGREE is handled.
- Training events during ISSUE still update the table but never start a burst (dropped trigger).
- Latency: trigger at T → first push at edge T+1 → dmem_valid=1 in cycle T+2. One push per cycle maximum.
- Output: dmem_valid = queue non-empty. Head dequeues on dmem_valid & dmem_ready. dmem_bits_addr = P<<LINE_SHIFT with low bits zero. dmem_bits_write = WRITE_HINT & is_store. Address and write stay stable while valid & !ready.
- Full queue with simultaneous pop: the push is still blocked that cycle (full is evaluated pre-pop). Empty queue with a push: data appears the next cycle, with no bypass.
- The last-pushed register clears on reset only.

Decomposition:
- Package l1_prefetch_pkg: M_XRD/M_XWR constants, stream-entry struct {valid, last, stride, conf}, FSM enum, line-width localparam function.
- One sub-module: prefetch_queue. Parametrised synchronous FIFO (QDEPTH entries of {addr, write}) with push/full and valid/ready pop.

Test Plan:
- Hold reset=0 for 3 cycles while driving misses → dmem_valid=0 throughout; after reset=1, no output until the first trigger.
- Read misses at 0x1000, 0x1040, 0x1080, ready=1 → outputs 0x10C0, then 0x1100, write=0. A 4th miss at 0x10C0 → 0x1100 is suppressed as duplicate, only 0x1140 is issued.
- Store misses at 0x8000, 0x7F00, 0x7E00 (stride −4 lines) → 0x7D00, 0x7C00 with write=1; with WRITE_HINT=0, write=0.
- Misses at 0x1F00, 0x1F40, 0x1F80 → only 0x1FC0 is issued; 0x2000 is suppressed (page cross).
- DEGREE=6, QDEPTH=4, ready=0 on a trigger → 4 entries held, addr stable, FSM stalls at k=5. Raise ready → all 6 addresses drain in order, one per cycle.
- Miss flag alignment: cpu_req valid at t with cpu_miss at t+1 only → no training; cpu_miss at t+2 → trains. cmd=2 → never trains.
